// File: rtl/lane_column_if.sv
// Lane bus between the playfield controller and one lane_column note engine.
// The LFSR input is named rand_val because "rand" is a reserved SystemVerilog keyword.
interface lane_column_if #(
  parameter int ROWS   = 8,
  parameter int RAND_W = 9
);
  logic              tick;
  logic [RAND_W-1:0] rand_val;
  logic [RAND_W-1:0] threshold;
  logic              key;
  logic [ROWS-1:0]   lights;
  logic              add2;
  logic              add1;
  logic              sub2;
  logic [3:0]        combo;

  modport master (
    output tick, rand_val, threshold, key,
    input  lights, add2, add1, sub2, combo
  );

  modport slave (
    input  tick, rand_val, threshold, key,
    output lights, add2, add1, sub2, combo
  );
endinterface

// File: rtl/lane_column.sv
// Single-lane DDR note engine: spawns, scrolls and judges notes, emits score pulses.
// Optional hit-streak counter on the combo output is enabled by defining LANE_COMBO_EN.
module lane_column #(
  parameter int ROWS   = 8,
  parameter int RAND_W = 9
) (
  input logic         Clock,
  input logic         Reset,
  lane_column_if.slave lane
);

  logic [ROWS-1:0] lights_q;
  logic [ROWS-1:0] lights_d;
  logic [ROWS-1:0] judged;
  logic            add2_q, add1_q, sub2_q;
  logic            add2_d, add1_d, sub2_d;
  logic            spawn;

  // Judge first against the pre-edge rows, then scroll the judged rows so a hit note
  // never propagates or counts as a miss; the three pulses are mutually exclusive by
  // construction (a miss needs the gold row occupied, which would have been a hit).
  always_comb begin
    judged = lights_q;
    add2_d = 1'b0;
    add1_d = 1'b0;
    sub2_d = 1'b0;
    if (lane.key) begin
      if (lights_q[ROWS-1]) begin
        judged[ROWS-1] = 1'b0;
        add2_d         = 1'b1;
      end else if (lights_q[ROWS-2]) begin
        judged[ROWS-2] = 1'b0;
        add1_d         = 1'b1;
      end else begin
        sub2_d = 1'b1;
      end
    end
    spawn    = (lane.rand_val < lane.threshold) && !lights_q[0];
    lights_d = judged;
    if (lane.tick) begin
      lights_d = {judged[ROWS-2:0], spawn};
      if (judged[ROWS-1]) begin
        sub2_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      lights_q <= '0;
      add2_q   <= 1'b0;
      add1_q   <= 1'b0;
      sub2_q   <= 1'b0;
    end else begin
      lights_q <= lights_d;
      add2_q   <= add2_d;
      add1_q   <= add1_d;
      sub2_q   <= sub2_d;
    end
  end

  assign lane.lights = lights_q;
  assign lane.add2   = add2_q;
  assign lane.add1   = add1_q;
  assign lane.sub2   = sub2_q;

`ifdef LANE_COMBO_EN
  logic [3:0] combo_q;

  // Streak follows the same next-cycle pulse decisions so it lines up with the pulses.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      combo_q <= 4'd0;
    end else if (add2_d || add1_d) begin
      if (combo_q != 4'd15) begin
        combo_q <= combo_q + 4'd1;
      end
    end else if (sub2_d) begin
      combo_q <= 4'd0;
    end
  end

  assign lane.combo = combo_q;
`else
  assign lane.combo = 4'd0;
`endif

endmodule

// File: tb/tb_lane_column.sv
// Self-checking bench for lane_column: directed test-plan scenarios plus randomized
// traffic, compared every cycle against a row-array model of the lane rules.
module tb_lane_column;
  localparam int ROWS   = 8;
  localparam int RAND_W = 9;
  localparam logic [RAND_W-1:0] MAX_VAL = '1;

  logic Clock;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  lane_column_if #(.ROWS(ROWS), .RAND_W(RAND_W)) bus ();

  lane_column #(.ROWS(ROWS), .RAND_W(RAND_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .lane  (bus.slave)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  bit m_rows[ROWS];
  bit m_add2, m_add1, m_sub2;
  int m_combo;

  function automatic logic [ROWS-1:0] model_lights();
    logic [ROWS-1:0] v;
    for (int i = 0; i < ROWS; i++) v[i] = m_rows[i];
    return v;
  endfunction

  // Behavioural model: rows as an array of note flags, updated from the lane rules.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < ROWS; i++) m_rows[i] = 1'b0;
      m_add2 = 0; m_add1 = 0; m_sub2 = 0; m_combo = 0;
    end else begin
      bit top_was_full;
      bit lost;
      m_add2 = 0; m_add1 = 0; m_sub2 = 0;
      if (bus.key) begin
        if (m_rows[ROWS-1]) begin
          m_rows[ROWS-1] = 0; m_add2 = 1;
        end else if (m_rows[ROWS-2]) begin
          m_rows[ROWS-2] = 0; m_add1 = 1;
        end else begin
          m_sub2 = 1;
        end
      end
      if (bus.tick) begin
        top_was_full = m_rows[0];
        lost = m_rows[ROWS-1];
        for (int i = ROWS-1; i > 0; i--) m_rows[i] = m_rows[i-1];
        m_rows[0] = (int'(bus.rand_val) < int'(bus.threshold)) && !top_was_full;
        if (lost) m_sub2 = 1;
      end
`ifdef LANE_COMBO_EN
      if (m_add1 || m_add2) m_combo = (m_combo < 15) ? m_combo + 1 : 15;
      else if (m_sub2) m_combo = 0;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    checkOutput("lights", bus.lights, model_lights());
    checkOutput("add2", bus.add2, m_add2);
    checkOutput("add1", bus.add1, m_add1);
    checkOutput("sub2", bus.sub2, m_sub2);
    checkOutput("combo", bus.combo, m_combo[3:0]);
    checkOutput("pulse_exclusive", (32'(bus.add2) + 32'(bus.add1) + 32'(bus.sub2)) <= 1, 1);
  end

  // One cycle per call: inputs are held for the next edge, then returned to idle.
  task automatic applyStimulus(input bit t, input bit k, input logic [RAND_W-1:0] r,
                               input logic [RAND_W-1:0] th);
    bus.tick      = t;
    bus.key       = k;
    bus.rand_val  = r;
    bus.threshold = th;
    @(posedge Clock);
    #2;
    bus.tick = 1'b0;
    bus.key  = 1'b0;
  endtask

  logic [3:0] combo_sat;

  initial begin
`ifdef LANE_COMBO_EN
    combo_sat = 4'd15;
`else
    combo_sat = 4'd0;
`endif
    Reset = 1'b1;
    bus.tick = 0; bus.key = 0; bus.rand_val = '0; bus.threshold = '0;
    repeat (3) @(posedge Clock);
    #2;
    checkOutput("reset_lights", bus.lights, 0);
    checkOutput("reset_combo", bus.combo, 0);
    Reset = 1'b0;

    repeat (20) applyStimulus(1, 0, RAND_W'($urandom_range(0, 511)), 0);
    checkOutput("idle_lights", bus.lights, 0);

    repeat (8) applyStimulus(1, 0, 0, MAX_VAL);
    checkOutput("spawn_gap", bus.lights, 8'b10101010);

    applyStimulus(0, 1, 0, 0);
    checkOutput("gold_add2", bus.add2, 1);
    checkOutput("gold_lights", bus.lights, 8'b00101010);
    applyStimulus(1, 0, 0, 0);
    checkOutput("gold_no_miss", bus.sub2, 0);
    checkOutput("gold_scroll", bus.lights, 8'b01010100);

    applyStimulus(0, 1, 0, 0);
    checkOutput("orange_add1", bus.add1, 1);
    checkOutput("orange_lights", bus.lights, 8'b00010100);
    applyStimulus(0, 1, 0, 0);
    checkOutput("stray_sub2", bus.sub2, 1);
    checkOutput("stray_lights", bus.lights, 8'b00010100);

    repeat (3) applyStimulus(1, 0, 0, 0);
    checkOutput("pre_simul", bus.lights, 8'b10100000);
    applyStimulus(1, 1, 0, 0);
    checkOutput("simul_add2", bus.add2, 1);
    checkOutput("simul_no_sub2", bus.sub2, 0);
    checkOutput("simul_lights", bus.lights, 8'b01000000);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("miss_sub2", bus.sub2, 1);
    checkOutput("miss_lights", bus.lights, 0);

    repeat (8) applyStimulus(1, 0, 0, MAX_VAL);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 1, 0, MAX_VAL);
      if (i == 16) checkOutput("combo_saturated", bus.combo, combo_sat);
      applyStimulus(1, 0, 0, MAX_VAL);
      applyStimulus(1, 0, 0, MAX_VAL);
    end
    applyStimulus(1, 0, 0, MAX_VAL);
    checkOutput("combo_miss_sub2", bus.sub2, 1);
    checkOutput("combo_cleared", bus.combo, 0);

    applyStimulus(1, 0, 0, MAX_VAL);
    applyStimulus(0, 1, 0, MAX_VAL);
    checkOutput("pre_reset_add2", bus.add2, 1);
    #1 Reset = 1'b1;
    #1;
    checkOutput("async_add2", bus.add2, 0);
    checkOutput("async_lights", bus.lights, 0);
    checkOutput("async_combo", bus.combo, 0);
    @(posedge Clock);
    #2 Reset = 1'b0;

    for (int n = 0; n < 600; n++) begin
      logic [RAND_W-1:0] r, th;
      case ($urandom_range(0, 3))
        0: th = 0;
        1: th = MAX_VAL;
        default: th = RAND_W'($urandom_range(0, 511));
      endcase
      r = ($urandom_range(0, 7) == 0) ? MAX_VAL : RAND_W'($urandom_range(0, 511));
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), r, th);
      if ($urandom_range(0, 99) == 0) begin
        #1 Reset = 1'b1;
        @(posedge Clock);
        #2 Reset = 1'b0;
      end
    end

    @(posedge Clock);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lane_column.md
# lane_column

Single-lane note engine for the DDR playfield. It spawns notes at the top row from the LFSR random value against the SW probability threshold and scrolls them down one row per `tick`. It judges the debounced `userIn` key pulse against the two bottom rows and emits the one-cycle `add2`/`add1`/`sub2` pulses consumed by `scoreCountOnes`. Its `lights` vector feeds the column MUX8to1 pair that drives the LED matrix.

## Interface
Parameters:
- `ROWS`, default 8: rows in the lane. Legal range 3..8. Row 0 is the top; row `ROWS-1` is the gold target row; row `ROWS-2` is the orange early row.
- `RAND_W`, default 9: width of `rand` and `threshold`.

Ports:
- `Clock`  in  1: single system clock (the divided clock used by the game logic).
- `Reset`  in  1: asynchronous, active-high; tied to SW[9].
- `tick`  in  1: one-cycle scroll strobe (the `is1` output).
- `rand`  in  `RAND_W`: LFSR9 value, unsigned.
- `threshold`  in  `RAND_W`: spawn probability from SW[8:0], unsigned.
- `key`  in  1: one-cycle press pulse from `userIn`.
- `lights`  out  `ROWS`: registered note occupancy; bit i is row i.
- `add2`  out  1: registered pulse for a gold-row hit.
- `add1`  out  1: registered pulse for an orange-row hit.
- `sub2`  out  1: registered pulse for a miss or a stray press.
- `combo`  out  4: hit streak (see Configuration).

## Operation
- All state updates on the rising edge of `Clock`. `Reset` clears all state asynchronously.
- Reset values: `lights`=0, `add2`=`add1`=`sub2`=0, `combo`=0.
- Judgement runs in every cycle with `key`=1 and uses the pre-edge `lights`:
  - If `lights[ROWS-1]`=1: clear that bit and pulse `add2`.
  - Else if `lights[ROWS-2]`=1: clear that bit and pulse `add1`.
  - Else: stray press; pulse `sub2`, no change to `lights`.
  - At most one note is cleared per press.
- Scroll runs in every cycle with `tick`=1, applied after any judgement clear in the same cycle:
  - `lights[i]` takes `lights[i-1]` for i = 1..ROWS-1.
  - `lights[0]` takes `spawn`, where `spawn` = (`rand` < `threshold`) AND NOT `lights[0]`. This forces at least one empty row between consecutive notes.
  - A note shifted out of row `ROWS-1` that was not hit this cycle is a miss and pulses `sub2`.
- Simultaneous `key` and `tick`:
  - A gold-row note hit in that cycle scores `add2` only; it is not also a miss.
  - A note cleared by the hit does not propagate.
  - At most one of `add2`/`add1`/`sub2` is asserted in any cycle.
- Spawn boundary cases:
  - `threshold`=0: never spawn.
  - `threshold`=2^RAND_W-1: spawn unless `rand` is all-ones, subject to the gap rule.
- `key` and `tick` are ignored while `Reset` is high.
- Reset asserted mid-pulse clears the pulse immediately.

## Timing
- `lights` reflects a scroll or a clear one cycle after the `tick`/`key` cycle (registered, one-cycle latency).
- Score pulses assert in the cycle after the triggering edge and last exactly one `Clock` cycle.
- No combinational path from any input to any output.
- Back-to-back `key` pulses in consecutive cycles are each judged against the state updated by the previous press.

## Configuration
- `LANE_COMBO_EN` defined:
  - `combo` increments with saturation at 15 on every `add1` or `add2` event.
  - It clears to 0 on every `sub2` event.
  - It updates in the same edge as the pulse register.
- `LANE_COMBO_EN` undefined:
  - `combo` is tied to 4'd0 and no counter logic is synthesised.
  - All other behaviour is identical.

## Test plan
- Reset-then-idle: with `threshold`=0, apply 20 ticks. Required: `lights` stays 0 and no pulses.
- Spawn gap: with `threshold`=511 and `rand`=0 constant, apply 8 ticks. Required: `lights` (ROWS=8) ends at 8'b10101010 (bit 7 first).
- Gold hit: place a single note at row 7, then press `key` with no tick. Required: `add2` for one cycle and `lights[7]`=0. Then tick once: no `sub2`.
- Orange hit and stray press: a note at row 6 plus `key` gives `add1` and clears row 6. A second `key` with the lane empty gives `sub2`; `lights` is unchanged.
- Miss and simultaneous event:
  - A note at row 7 with a tick and no key gives `sub2` one cycle later.
  - A note at row 7 with `key` and `tick` in the same cycle gives `add2` only; the row-6 contents move to row 7.
- Combo (`LANE_COMBO_EN` defined): 17 consecutive hits give `combo`=15 (saturated). A following miss gives `combo`=0. Asserting `Reset` mid-run clears `combo` and `lights` asynchronously.
